// File: rtl/mrisc_multicycle_ctrl.sv
// Multi-cycle control FSM for the KGP mini-RISC datapath.
// Moore outputs decode from state plus opcode/func latched on exit from FETCH.
module mrisc_multicycle_ctrl #(
    parameter int unsigned FETCH_WAIT = 1,
    parameter int unsigned MEM_WAIT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    output logic [1:0]  reg_write,
    output logic        imm_mux_ctrl,
    output logic        alu_mux_ctrl,
    output logic [3:0]  alu_op,
    output logic        dmem_enable,
    output logic        dmem_write_enable,
    output logic [1:0]  reg_write_mux_ctrl,
    output logic [4:0]  br_op,
    output logic        pc_en,
    output logic        halted,
    output logic        trap,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_IMM  = 6'b000001;
    localparam logic [5:0] OP_LW   = 6'b000010;
    localparam logic [5:0] OP_SW   = 6'b000011;
    localparam logic [5:0] OP_BR   = 6'b000100;
    localparam logic [5:0] OP_CALL = 6'b000101;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] FW_LAST = 3'(FETCH_WAIT - 1);
    localparam logic [2:0] MW_LAST = 3'(MEM_WAIT - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [5:0]  op_q, op_d;
    logic [5:0]  fn_q, fn_d;
    logic [15:0] icnt_q, icnt_d;

    logic is_r, is_imm, is_lw, is_sw, is_br, is_call, is_halt, is_legal;
    logic [3:0] ex_alu_op;
    logic       ex_alu_mux, ex_imm_mux;
    logic       unused_fn_hi;

    assign is_r     = (op_q == OP_R);
    assign is_imm   = (op_q == OP_IMM);
    assign is_lw    = (op_q == OP_LW);
    assign is_sw    = (op_q == OP_SW);
    assign is_br    = (op_q == OP_BR);
    assign is_call  = (op_q == OP_CALL);
    assign is_halt  = (op_q == OP_HALT);
    assign is_legal = is_r | is_imm | is_lw | is_sw | is_br | is_call;

    // EXEC selects are held unchanged through MEM and WB
    assign ex_alu_op    = (is_r | is_imm) ? fn_q[3:0] : 4'b0000;
    assign ex_alu_mux   = is_imm | is_lw | is_sw;
    assign ex_imm_mux   = is_lw | is_sw;
    assign unused_fn_hi = &{1'b0, fn_q[5:4]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            fn_q    <= '0;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
            icnt_q  <= icnt_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        cnt_d              = '0;
        op_d               = op_q;
        fn_d               = fn_q;
        reg_write          = 2'b00;
        imm_mux_ctrl       = 1'b0;
        alu_mux_ctrl       = 1'b0;
        alu_op             = 4'b0000;
        dmem_enable        = 1'b0;
        dmem_write_enable  = 1'b0;
        reg_write_mux_ctrl = 2'b00;
        br_op              = 5'b00000;
        pc_en              = 1'b0;
        halted             = 1'b0;
        trap               = 1'b0;

        case (state_q)
            S_IDLE: if (run) state_d = S_FETCH;
            S_FETCH: begin
                if (cnt_q == FW_LAST) begin
                    op_d    = opcode;
                    fn_d    = func;
                    state_d = S_DECODE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DECODE: begin
                if (is_halt)        state_d = S_HALT;
                else if (!is_legal) state_d = S_TRAP;
                else                state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_op       = ex_alu_op;
                alu_mux_ctrl = ex_alu_mux;
                imm_mux_ctrl = ex_imm_mux;
                if (is_r || is_imm) begin
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    br_op = {1'b1, fn_q[3:0]};
                    pc_en = 1'b1;
                    if (is_call) reg_write = 2'b11;
                end
            end
            S_MEM: begin
                alu_op            = ex_alu_op;
                alu_mux_ctrl      = ex_alu_mux;
                imm_mux_ctrl      = ex_imm_mux;
                dmem_enable       = 1'b1;
                dmem_write_enable = is_sw && (cnt_q == 3'd0);
                if (cnt_q == MW_LAST) begin
                    if (is_sw) pc_en = 1'b1;
                    else       state_d = S_WB;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_WB: begin
                alu_op       = ex_alu_op;
                alu_mux_ctrl = ex_alu_mux;
                imm_mux_ctrl = ex_imm_mux;
                pc_en        = 1'b1;
                if (is_lw) begin
                    reg_write          = 2'b10;
                    reg_write_mux_ctrl = 2'b01;
                end else begin
                    reg_write          = 2'b01;
                    reg_write_mux_ctrl = 2'b10;
                end
            end
            S_HALT: halted = 1'b1;
            S_TRAP: trap = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // every retire point samples run to choose between the next fetch and idling
        if (pc_en) state_d = run ? S_FETCH : S_IDLE;
    end

    assign icnt_d      = (pc_en && (icnt_q != 16'hFFFF)) ? icnt_q + 16'd1 : icnt_q;
    assign instr_count = icnt_q;

endmodule
